// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Types and constants shared by the display scan controller and the
// segment-pattern decoder that consumes its digit index.
//   DIGIT_W     : width of the digit index (count_an)
//   MAX_DIGITS  : number of physical anode lines on the display
//   digit_idx_t : digit index type
//   anode_t     : active-low anode vector type
//   anode_decode: one-hot-low anode pattern for a digit index
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int DIGIT_W    = 3;
    localparam int MAX_DIGITS = 8;

    typedef logic [DIGIT_W-1:0]    digit_idx_t;
    typedef logic [MAX_DIGITS-1:0] anode_t;

    // Only the selected digit is driven low. Indices never exceed
    // NUM_DIGITS-1, so unused anodes above NUM_DIGITS stay high.
    function automatic anode_t anode_decode(input digit_idx_t idx);
        return ~(anode_t'(1) << idx);
    endfunction

endpackage

// File: rtl/display_scan_controller_sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Two-flop synchroniser followed by a debounce counter for the raw
// name-select switch.
// Parameters:
//   DEBOUNCE_CYCLES : consecutive cycles the synchronised value must differ
//                     from sw_stable before the change is accepted
// Ports:
//   clk       in  1  system clock
//   reset     in  1  synchronous, active-high reset
//   sw_in     in  1  raw asynchronous switch
//   sw_stable out 1  debounced switch value
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    output logic sw_stable
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // The switch is a single bit, so "synced value differs from sw_stable"
    // can only stay true while the synced value holds still; any change
    // makes it equal to sw_stable and clears the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            sw_stable <= 1'b0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
            if (sync2 == sw_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                sw_stable <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Scans an 8-digit multiplexed 7-segment display: prescales clk to a
// per-digit slot, cycles the digit index downwards, drives the matching
// active-low anode and hands a frame-stable name select to the decoder.
// Parameters:
//   TICK_DIV        : clk cycles per digit slot (>= 2)
//   NUM_DIGITS      : active digits, 1..8
//   DEBOUNCE_CYCLES : stable cycles needed to accept a switch change
//   BLANK_CYCLES    : all-anodes-off guard at slot start (< TICK_DIV)
// Configuration macro:
//   SCAN_BLANK_EN   : when defined, an is forced to all-ones while
//                     div_cnt < BLANK_CYCLES in every slot (ghost suppression)
// Ports:
//   clk         in  1  system clock
//   reset       in  1  synchronous, active-high reset
//   sw_in       in  1  raw asynchronous name-select switch
//   count_an    out 3  current digit index
//   an          out 8  anode enables, active low, one-hot-low
//   sw_sel      out 1  name select, only updated on frame wrap
//   frame_start out 1  one-cycle pulse after count_an wraps to NUM_DIGITS-1
// -----------------------------------------------------------------------------
module display_scan_controller
    import display_pkg::*;
#(
    parameter int TICK_DIV        = 100_000,
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLANK_CYCLES    = 1_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_in,
    output digit_idx_t count_an,
    output anode_t     an,
    output logic       sw_sel,
    output logic       frame_start
);

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam digit_idx_t       IDX_TOP  = digit_idx_t'(NUM_DIGITS - 1);

    // Elaboration-time parameter sanity checks.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
        $error("NUM_DIGITS must be in 1..8");
    end
    if (BLANK_CYCLES >= TICK_DIV) begin : g_bad_blank
        $error("BLANK_CYCLES must be < TICK_DIV");
    end

    logic             sw_stable;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             tick;
    logic             wrap;
    digit_idx_t       count_next;
    anode_t           an_next;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .sw_in    (sw_in),
        .sw_stable(sw_stable)
    );

    // an is registered from the *next* index and divider value so that it
    // changes on the same edge as count_an and never lags it by a cycle.
    always_comb begin
        tick       = (div_cnt == DIV_LAST);
        wrap       = tick && (count_an == '0);
        div_next   = tick ? '0 : div_cnt + 1'b1;
        count_next = count_an;
        if (tick) begin
            count_next = (count_an == '0) ? IDX_TOP : count_an - 1'b1;
        end
        an_next = anode_decode(count_next);
`ifdef SCAN_BLANK_EN
        if (div_next < DIV_W'(BLANK_CYCLES)) begin
            an_next = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            count_an    <= IDX_TOP;
            an          <= '1;
            sw_sel      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_next;
            count_an    <= count_next;
            an          <= an_next;
            frame_start <= wrap;
            // sw_stable is sampled before any same-edge update inside the
            // debouncer, so a change accepted on a wrap edge waits a frame.
            if (wrap) begin
                sw_sel <= sw_stable;
            end
        end
    end

endmodule
